board_fetch_sched: RTL
======================

// Module: board_fetch_sched
// PURPOSE
//  Owns the 64-square board store; arbitrates its single RAM port between the raster fetch and game-logic moves.
//  Prefetches each square's piece code ahead of the beam and presents it, with cell origin, to the sprite renderer.
//  Sits between vga timing / game FSM and image_sprite; loads the initial position after reset or on request.
// PARAMETERS
//  GRID    60  cell pitch, pixels
//  MARGIN  10  sprite inset inside a cell, pixels
//  LEAD    2   fetch issue lead before sprite start (RAM 1-cycle latency + output reg)
// PORTS
//  clk_65mhz    in   1   pixel clock
//  nrst         in   1   asynchronous, active-low reset
//  hcount_in    in   11  pixel on current line (from vga)
//  vcount_in    in   10  line number (from vga)
//  init_req_i   in   1   reload initial position; accepted only in IDLE
//  mv_valid_i   in   1   move request valid
//  mv_ready_o   out  1   high only in IDLE with init_done_o=1
//  mv_from_i    in   6   source square, row*8+col
//  mv_to_i      in   6   destination square
//  mv_done_o    out  1   1-cycle pulse: move completed
//  mv_err_o     out  1   1-cycle pulse: move rejected (source EMPTY)
//  init_done_o  out  1   board valid
//  piece_sel_o  out  8   {colour[1:0], piece[5:0]} of current cell, to sprite
//  cell_x_o     out  11  GRID*col+MARGIN-1
//  cell_y_o     out  10  GRID*row+MARGIN-1
// BEHAVIOUR
//  Reset: all outputs 0 except piece_sel_o=EMPTY (8'h7F); FSM -> INIT, init address 0. Mid-op reset aborts, restarts INIT.
//  Render slot: vcount_in<8*GRID and hcount_in==GRID*c+MARGIN-LEAD, c=0..7 (8,68,..,428). Read addr row*8+c.
//   row/col from incremental counters (no divide/modulo); row = vcount_in/GRID.
//  RAM dout valid next cycle; piece_sel_o/cell_x_o/cell_y_o registered, new value valid from hcount_in==GRID*c+MARGIN,
//   held until next slot. While init_done_o=0, piece_sel_o forced EMPTY.
//  Arbitration: render slot has absolute priority; any FSM RAM access due that cycle stalls one cycle (state held).
//  FSM states:
//   INIT   : write INIT_BOARD[a] to a, a=0..63 (non-slot cycles only); after a=63 -> IDLE, init_done_o=1.
//   IDLE   : mv_valid_i&mv_ready_o -> latch from/to; from==to -> DONE; else -> MV_RD.
//            init_req_i (priority over move same cycle) -> init_done_o=0, INIT.
//   MV_RD  : issue read of from -> MV_CAP.
//   MV_CAP : capture dout; EMPTY -> ERR; else -> MV_WTO.
//   MV_WTO : write captured code to to -> MV_WFR.
//   MV_WFR : write EMPTY to from -> DONE.
//   DONE   : mv_done_o=1 one cycle -> IDLE.  ERR: mv_err_o=1 one cycle, board untouched -> IDLE.
//  Move latency, no stalls: accept->mv_done_o = 5 cycles; each coinciding render slot adds 1.
//  A render read of a square in the cycle after its write returns the new value (write-first visibility not required same cycle).
//  No legality checking; destination overwritten unconditionally (capture).
// STRUCTURE
//  chess_pkg: EMPTY, piece one-hots, WHITE/BLACK, GRID, MARGIN, INIT_BOARD[64] constant, fsm state enum.
//  Sub-module board_ram: 64x8 single-port sync RAM, 1-cycle read, write-first unused.
//  Top: slot generator + row/col counters, FSM, port mux, output registers.
// TESTING
//  Reset, hold vcount_in>=480 -> init_done_o rises 64 cycles after nrst release; raster frame shows sq0=8'h44, sq63=8'h84.
//  Move 12->28 in blanking -> mv_done_o 5 cycles after accept; next frame sq28=8'h60, sq12=8'h7F.
//  Move 20->36 (sq20 EMPTY) -> mv_err_o pulse, mv_done_o stays 0, board unchanged.
//  Accept move so MV_RD lands at hcount_in==68, vcount_in<480 -> FSM stalls 1 cycle; cell 1 piece_sel_o correct; done at 6 cycles.
//  mv_valid_i held during INIT -> mv_ready_o=0, no accept until init_done_o=1; init_req_i+mv_valid_i same IDLE cycle -> init wins.
//  nrst pulsed in MV_WTO -> init reruns, board equals INIT_BOARD, no mv_done_o pulse.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared constants for the chess board store: piece encodings, raster
// geometry, the start position and the board fetch/move FSM states.
package chess_pkg;

   // Piece code is {colour[1:0], piece_onehot[5:0]}; an empty square has its own code.
   localparam logic [7:0] EMPTY    = 8'h7F;

   localparam logic [5:0] P_KING   = 6'b000001;
   localparam logic [5:0] P_QUEEN  = 6'b000010;
   localparam logic [5:0] P_ROOK   = 6'b000100;
   localparam logic [5:0] P_BISHOP = 6'b001000;
   localparam logic [5:0] P_KNIGHT = 6'b010000;
   localparam logic [5:0] P_PAWN   = 6'b100000;

   // Rows 0-1 (top of screen) hold one side, rows 6-7 the other.
   localparam logic [1:0] BLACK    = 2'b01;
   localparam logic [1:0] WHITE    = 2'b10;

   // Raster geometry: cell pitch, sprite inset, and fetch lead ahead of the sprite.
   localparam int GRID   = 60;
   localparam int MARGIN = 10;
   localparam int LEAD   = 2;

   localparam logic [10:0] GRID_H     = 11'(GRID);
   localparam logic [9:0]  GRID_V     = 10'(GRID);
   localparam logic [10:0] SLOT0_H    = 11'(MARGIN - LEAD);
   localparam logic [10:0] CELL_H_OFS = 11'(LEAD - 1);
   localparam logic [9:0]  CELL_V_OFS = 10'(MARGIN - 1);
   localparam logic [9:0]  ACTIVE_V   = 10'(8 * GRID);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_MV_RD,
      ST_MV_CAP,
      ST_MV_WTO,
      ST_MV_WFR,
      ST_DONE,
      ST_ERR
   } fsm_state_t;

   // Start position (INIT_BOARD), indexed by square row*8+col.
   function automatic logic [7:0] init_board(input logic [5:0] sq);
      logic [5:0] back;
      logic [7:0] code;
      case (sq[2:0])
         3'd0, 3'd7: back = P_ROOK;
         3'd1, 3'd6: back = P_KNIGHT;
         3'd2, 3'd5: back = P_BISHOP;
         3'd3:       back = P_QUEEN;
         3'd4:       back = P_KING;
         default:    back = P_ROOK;
      endcase
      case (sq[5:3])
         3'd0:    code = {BLACK, back};
         3'd1:    code = {BLACK, P_PAWN};
         3'd6:    code = {WHITE, P_PAWN};
         3'd7:    code = {WHITE, back};
         default: code = EMPTY;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/board_ram.sv
// 64x8 single-port synchronous board store; read data appears one cycle
// after the address. A write cycle returns the old contents.
module board_ram
   import chess_pkg::*;
(
   input  logic       clk_65mhz,
   input  logic       nrst,
   input  logic       we,
   input  logic [5:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata
);

   logic [7:0] mem [64];

   // Storage array: written on demand, never reset (contents loaded by INIT).
   always_ff @(posedge clk_65mhz) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Registered read port.
   always_ff @(posedge clk_65mhz or negedge nrst) begin
      if (!nrst) begin
         rdata <= EMPTY;
      end else begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/board_fetch_sched.sv
// Board store owner: prefetches each square's piece code ahead of the beam
// for the sprite renderer and shares the single RAM port with the
// init/move FSM. Render slots always win the port; the FSM waits a cycle.
module board_fetch_sched
   import chess_pkg::*;
(
   input  logic        clk_65mhz,
   input  logic        nrst,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        init_req_i,
   input  logic        mv_valid_i,
   output logic        mv_ready_o,
   input  logic [5:0]  mv_from_i,
   input  logic [5:0]  mv_to_i,
   output logic        mv_done_o,
   output logic        mv_err_o,
   output logic        init_done_o,
   output logic [7:0]  piece_sel_o,
   output logic [10:0] cell_x_o,
   output logic [9:0]  cell_y_o
);

   // Raster tracking: column slot position and row, kept incrementally.
   logic [3:0]  col;
   logic [10:0] slot_h;
   logic [2:0]  row;
   logic [9:0]  row_y;
   logic [9:0]  next_row_v;
   logic        slot;

   // Render pipeline stage between RAM read and output registers.
   logic        rd_pend;
   logic [10:0] pend_x;
   logic [9:0]  pend_y;

   // FSM state and datapath registers.
   fsm_state_t  state, state_next;
   logic [5:0]  init_addr, init_addr_next;
   logic [5:0]  mv_src, mv_src_next;
   logic [5:0]  mv_dst, mv_dst_next;
   logic [7:0]  cap_code, cap_code_next;
   logic        init_done_next;
   logic        done_next;
   logic        err_next;
   logic        stall;

   // FSM side of the RAM port.
   logic        fsm_we;
   logic [5:0]  fsm_addr;
   logic [7:0]  fsm_wdata;

   // Shared RAM port.
   logic        ram_we;
   logic [5:0]  ram_addr;
   logic [7:0]  ram_dout;

   // A slot fires once per visible cell, LEAD pixels before the sprite starts.
   assign slot = (vcount_in < ACTIVE_V) && !col[3] && (hcount_in == slot_h);

   // Port mux: a render slot takes the port; FSM writes are suppressed then.
   assign ram_addr = slot ? {row, col[2:0]} : fsm_addr;
   assign ram_we   = !slot && fsm_we;

   board_ram u_ram (
      .clk_65mhz (clk_65mhz),
      .nrst      (nrst),
      .we        (ram_we),
      .addr      (ram_addr),
      .wdata     (fsm_wdata),
      .rdata     (ram_dout)
   );

   // Column/row counters: restart each line and frame, step at slots / row boundaries.
   always_ff @(posedge clk_65mhz or negedge nrst) begin
      if (!nrst) begin
         col        <= 4'd0;
         slot_h     <= SLOT0_H;
         row        <= 3'd0;
         row_y      <= 10'd0;
         next_row_v <= GRID_V;
      end else if (hcount_in == 11'd0) begin
         col    <= 4'd0;
         slot_h <= SLOT0_H;
         if (vcount_in == 10'd0) begin
            row        <= 3'd0;
            row_y      <= 10'd0;
            next_row_v <= GRID_V;
         end else if (vcount_in == next_row_v) begin
            row        <= row + 3'd1;
            row_y      <= next_row_v;
            next_row_v <= next_row_v + GRID_V;
         end
      end else if (slot) begin
         col    <= col + 4'd1;
         slot_h <= slot_h + GRID_H;
      end
   end

   // Remember the cell origin of the read in flight until its data returns.
   always_ff @(posedge clk_65mhz or negedge nrst) begin
      if (!nrst) begin
         rd_pend <= 1'b0;
         pend_x  <= 11'd0;
         pend_y  <= 10'd0;
      end else begin
         rd_pend <= slot;
         if (slot) begin
            pend_x <= slot_h + CELL_H_OFS;
            pend_y <= row_y + CELL_V_OFS;
         end
      end
   end

   // Sprite outputs: load when read data arrives, hold to the next slot, blank while board invalid.
   always_ff @(posedge clk_65mhz or negedge nrst) begin
      if (!nrst) begin
         piece_sel_o <= EMPTY;
         cell_x_o    <= 11'd0;
         cell_y_o    <= 10'd0;
      end else if (rd_pend) begin
         piece_sel_o <= init_done_o ? ram_dout : EMPTY;
         cell_x_o    <= pend_x;
         cell_y_o    <= pend_y;
      end else if (!init_done_o) begin
         piece_sel_o <= EMPTY;
      end
   end

   // FSM next state, RAM requests and pulse outputs; a RAM-using state waits out a render slot.
   always_comb begin
      state_next     = state;
      init_addr_next = init_addr;
      mv_src_next    = mv_src;
      mv_dst_next    = mv_dst;
      cap_code_next  = cap_code;
      init_done_next = init_done_o;
      done_next      = 1'b0;
      err_next       = 1'b0;
      fsm_we         = 1'b0;
      fsm_addr       = 6'd0;
      fsm_wdata      = EMPTY;

      stall = slot && (state inside {ST_INIT, ST_MV_RD, ST_MV_WTO, ST_MV_WFR});

      if (stall) begin
         state_next = state;
      end else begin
         case (state)
            ST_INIT: begin
               fsm_we    = 1'b1;
               fsm_addr  = init_addr;
               fsm_wdata = init_board(init_addr);
               if (init_addr == 6'd63) begin
                  state_next     = ST_IDLE;
                  init_done_next = 1'b1;
               end else begin
                  init_addr_next = init_addr + 6'd1;
               end
            end
            ST_IDLE: begin
               if (init_req_i) begin
                  state_next     = ST_INIT;
                  init_addr_next = 6'd0;
                  init_done_next = 1'b0;
               end else if (mv_valid_i && mv_ready_o) begin
                  mv_src_next = mv_from_i;
                  mv_dst_next = mv_to_i;
                  if (mv_from_i == mv_to_i) begin
                     state_next = ST_DONE;
                     done_next  = 1'b1;
                  end else begin
                     state_next = ST_MV_RD;
                  end
               end else begin
                  state_next = ST_IDLE;
               end
            end
            ST_MV_RD: begin
               fsm_addr   = mv_src;
               state_next = ST_MV_CAP;
            end
            ST_MV_CAP: begin
               cap_code_next = ram_dout;
               if (ram_dout == EMPTY) begin
                  state_next = ST_ERR;
                  err_next   = 1'b1;
               end else begin
                  state_next = ST_MV_WTO;
               end
            end
            ST_MV_WTO: begin
               fsm_we     = 1'b1;
               fsm_addr   = mv_dst;
               fsm_wdata  = cap_code;
               state_next = ST_MV_WFR;
            end
            ST_MV_WFR: begin
               fsm_we     = 1'b1;
               fsm_addr   = mv_src;
               fsm_wdata  = EMPTY;
               state_next = ST_DONE;
               done_next  = 1'b1;
            end
            ST_DONE: begin
               state_next = ST_IDLE;
            end
            ST_ERR: begin
               state_next = ST_IDLE;
            end
            default: begin
               state_next     = ST_INIT;
               init_addr_next = 6'd0;
               init_done_next = 1'b0;
            end
         endcase
      end
   end

   // FSM state register and registered handshake/status outputs.
   always_ff @(posedge clk_65mhz or negedge nrst) begin
      if (!nrst) begin
         state       <= ST_INIT;
         init_addr   <= 6'd0;
         mv_src      <= 6'd0;
         mv_dst      <= 6'd0;
         cap_code    <= EMPTY;
         init_done_o <= 1'b0;
         mv_ready_o  <= 1'b0;
         mv_done_o   <= 1'b0;
         mv_err_o    <= 1'b0;
      end else begin
         state       <= state_next;
         init_addr   <= init_addr_next;
         mv_src      <= mv_src_next;
         mv_dst      <= mv_dst_next;
         cap_code    <= cap_code_next;
         init_done_o <= init_done_next;
         mv_ready_o  <= (state_next == ST_IDLE) && init_done_next;
         mv_done_o   <= done_next;
         mv_err_o    <= err_next;
      end
   end

endmodule
